// File: rtl/uart_rx_if.sv
// Byte-side and serial-side signals of the UART receiver.
// The master modport is the side that drives the line and the acknowledge.
// The slave modport is the receiver itself.
interface uart_rx_if;
  logic       rx;
  logic       clken;
  logic       rdy_clr;
  logic [7:0] data;
  logic       rdy;
  logic       frame_err;
  logic       overrun;
  logic       rx_busy;

  modport master (
    output rx, clken, rdy_clr,
    input  data, rdy, frame_err, overrun, rx_busy
  );

  modport slave (
    input  rx, clken, rdy_clr,
    output data, rdy, frame_err, overrun, rx_busy
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, using a 16x (OVERSAMPLE) enable strobe.
// The line passes through a 2-flop synchronizer. Each bit is sampled at its
// centre: the start bit is counted to MID-1, then a full bit period follows
// for each data bit and for the stop bit. The receiver drops back to IDLE at
// mid-stop-bit, so a start bit that follows directly is still caught.
module uart_rx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic     clk_50m,
  input  logic     rst,
  uart_rx_if.slave bus
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] MID_LAST = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q,  state_d;
  logic [1:0]    sync_q,   sync_d;
  logic [CW-1:0] cnt_q,    cnt_d;
  logic [2:0]    bitpos_q, bitpos_d;
  logic [7:0]    shift_q,  shift_d;
  logic [7:0]    data_q,   data_d;
  logic          rdy_q,    rdy_d;
  logic          ferr_q,   ferr_d;
  logic          ovr_q,    ovr_d;
  logic          rx_s;
  logic          good_stop;

  assign rx_s = sync_q[1];

  // Next-state logic: the FSM moves only on clken; the acknowledge acts every clock.
  always_comb begin
    state_d   = state_q;
    sync_d    = {sync_q[0], bus.rx};
    cnt_d     = cnt_q;
    bitpos_d  = bitpos_q;
    shift_d   = shift_q;
    data_d    = data_q;
    rdy_d     = rdy_q;
    ferr_d    = ferr_q;
    ovr_d     = ovr_q;
    good_stop = 1'b0;

    if (bus.clken) begin
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_d = START;
            cnt_d   = CNT_ONE;
          end
        end
        START: begin
          if (rx_s) begin
            // The line went high again before mid-start: treat it as a glitch.
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == MID_LAST) begin
            state_d  = DATA;
            cnt_d    = '0;
            bitpos_d = 3'd0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        DATA: begin
          if (cnt_q == CNT_LAST) begin
            shift_d[bitpos_q] = rx_s;
            cnt_d             = '0;
            if (bitpos_q == 3'd7) begin
              state_d = STOP;
            end else begin
              bitpos_d = bitpos_q + 3'd1;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        STOP: begin
          if (cnt_q == CNT_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
            if (rx_s) begin
              good_stop = 1'b1;
              data_d    = shift_q;
              ferr_d    = 1'b0;
              rdy_d     = 1'b1;
              if (rdy_q) begin
                ovr_d = 1'b1;
              end
            end else begin
              // A bad frame leaves the previously delivered byte untouched.
              ferr_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    // The acknowledge consumes the old byte. A byte landing on the same cycle is
    // new and keeps rdy set, and no overrun is raised because the old byte was taken.
    if (bus.rdy_clr) begin
      ovr_d = 1'b0;
      if (!good_stop) begin
        rdy_d = 1'b0;
      end
    end
  end

  // State and output registers; the synchronizer resets to the idle line level.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sync_q   <= 2'b11;
      cnt_q    <= '0;
      bitpos_q <= 3'd0;
      shift_q  <= 8'h00;
      data_q   <= 8'h00;
      rdy_q    <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      bitpos_q <= bitpos_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      rdy_q    <= rdy_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
    end
  end

  assign bus.data      = data_q;
  assign bus.rdy       = rdy_q;
  assign bus.frame_err = ferr_q;
  assign bus.overrun   = ovr_q;
  assign bus.rx_busy   = (state_q != IDLE);

endmodule
